// File: rtl/sar_logic_multi_if.sv
// Handshake and data bundle between the SAR controller and its channel/comparator environment.
// master: requester/analog front end side; slave: the sar_logic_multi controller.
interface sar_logic_multi_if #(
    parameter int unsigned BITS = 10,
    parameter int unsigned NCH  = 4
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            start;
    logic [CW-1:0]   ch_sel;
    logic            scan_en;
    logic            comp_in;
    logic [BITS-1:0] dac_code;
    logic            sample_en;
    logic [CW-1:0]   ch_mux;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;
    logic [CW-1:0]   result_ch;

    modport master (
        output start, ch_sel, scan_en, comp_in,
        input  dac_code, sample_en, ch_mux, busy, done, result, result_ch
    );

    modport slave (
        input  start, ch_sel, scan_en, comp_in,
        output dac_code, sample_en, ch_mux, busy, done, result, result_ch
    );
endinterface

// File: rtl/sar_logic_multi.sv
// Multi-channel SAR ADC controller: sample, binary-search convert, publish, optional round-robin scan.
// Optional 4-pass averaging is compiled in with the SAR_AVG_EN macro.
module sar_logic_multi #(
    parameter int unsigned BITS          = 10,
    parameter int unsigned NCH           = 4,
    parameter int unsigned SAMPLE_CYCLES = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    sar_logic_multi_if.slave     bus
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IW = $clog2(BITS);
    localparam int unsigned SW = 8;
`ifdef SAR_AVG_EN
    localparam int unsigned AW = BITS + 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    state_t          state_q, state_nxt;
    logic [SW-1:0]   cnt_q, cnt_nxt;
    logic [IW-1:0]   idx_q, idx_nxt;
    logic [BITS-1:0] dac_q, dac_nxt;
    logic [CW-1:0]   ch_q, ch_nxt;
    logic [BITS-1:0] result_q, result_nxt;
    logic [CW-1:0]   rch_q, rch_nxt;
    logic            sample_q, sample_nxt;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic [BITS-1:0] trial;
    logic [BITS-1:0] kept;
`ifdef SAR_AVG_EN
    logic [AW-1:0]   acc_q, acc_nxt;
    logic [1:0]      pass_q, pass_nxt;
    logic [AW-1:0]   sum;
`endif

    // State and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dac_q    <= '0;
            ch_q     <= '0;
            result_q <= '0;
            rch_q    <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SAR_AVG_EN
            acc_q    <= '0;
            pass_q   <= '0;
`endif
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            dac_q    <= dac_nxt;
            ch_q     <= ch_nxt;
            result_q <= result_nxt;
            rch_q    <= rch_nxt;
            sample_q <= sample_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
`ifdef SAR_AVG_EN
            acc_q    <= acc_nxt;
            pass_q   <= pass_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        idx_nxt    = idx_q;
        dac_nxt    = '0;
        ch_nxt     = ch_q;
        result_nxt = result_q;
        rch_nxt    = rch_q;
        trial      = BITS'(1) << idx_q;
        kept       = bus.comp_in ? dac_q : (dac_q & ~trial);
`ifdef SAR_AVG_EN
        acc_nxt    = acc_q;
        pass_nxt   = pass_q;
        sum        = acc_q + AW'(kept);
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_SAMPLE;
                    cnt_nxt   = '0;
                    ch_nxt    = (32'(bus.ch_sel) < NCH) ? bus.ch_sel : '0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == SW'(SAMPLE_CYCLES - 1)) begin
                    state_nxt = ST_CONVERT;
                    idx_nxt   = IW'(BITS - 1);
                    dac_nxt   = BITS'(1) << (BITS - 1);
                end else begin
                    cnt_nxt   = cnt_q + SW'(1);
                end
            end
            ST_CONVERT: begin
                if (idx_q == '0) begin
`ifdef SAR_AVG_EN
                    // Only the fourth pass publishes; earlier passes re-sample the same channel
                    if (pass_q == 2'd3) begin
                        state_nxt  = ST_DONE;
                        result_nxt = BITS'(sum >> 2);
                        rch_nxt    = ch_q;
                        acc_nxt    = '0;
                        pass_nxt   = '0;
                    end else begin
                        state_nxt  = ST_SAMPLE;
                        cnt_nxt    = '0;
                        acc_nxt    = sum;
                        pass_nxt   = pass_q + 2'd1;
                    end
`else
                    state_nxt  = ST_DONE;
                    result_nxt = kept;
                    rch_nxt    = ch_q;
`endif
                end else begin
                    idx_nxt = idx_q - IW'(1);
                    dac_nxt = kept | (trial >> 1);
                end
            end
            ST_DONE: begin
                if (bus.scan_en) begin
                    state_nxt = ST_SAMPLE;
                    cnt_nxt   = '0;
                    ch_nxt    = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        sample_nxt = (state_nxt == ST_SAMPLE);
        busy_nxt   = (state_nxt != ST_IDLE);
        done_nxt   = (state_nxt == ST_DONE);
    end

    assign bus.dac_code  = dac_q;
    assign bus.sample_en = sample_q;
    assign bus.ch_mux    = ch_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_ch = rch_q;

endmodule
